// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
// Size encodings, FSM states, byte-enable and load-extension functions.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // The reserved encoding behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_W : sz;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz,
                                           input logic [1:0] off);
        return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
    endfunction

    function automatic logic [1:0] force_align(input logic [1:0] sz,
                                               input logic [1:0] off);
        logic [1:0] r;
        r = off;
        unique case (1'b1)
            sz == SZ_H: r = {off[1], 1'b0};
            sz == SZ_W: r = 2'b00;
            default:    r = off;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] sz,
                                         input logic [1:0] off);
        logic [3:0] r;
        r = 4'b1111;
        unique case (1'b1)
            sz == SZ_B: r = 4'b0001 << off;
            sz == SZ_H: r = off[1] ? 4'b1100 : 4'b0011;
            default:    r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0]  sz,
                                              input logic [31:0] d);
        logic [31:0] r;
        r = d;
        unique case (1'b1)
            sz == SZ_B: r = {4{d[7:0]}};
            sz == SZ_H: r = {2{d[15:0]}};
            default:    r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ext_load(input logic [1:0]  sz,
                                             input logic        zext,
                                             input logic [1:0]  off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(rd >> {off, 3'b000});
        h = 16'(rd >> {off[1], 4'b0000});
        r = rd;
        unique case (1'b1)
            sz == SZ_B: r = zext ? {24'b0, b} : {{24{b[7]}}, b};
            sz == SZ_H: r = zext ? {16'b0, h} : {{16{h[15]}}, h};
            default:    r = rd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Datapath-side request/response bundle and data-memory bus.
// master = initiator of the transaction on each bundle.
interface lsu_req_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              misalign;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_err, resp_rdata, misalign
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_err, resp_rdata, misalign
    );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, replicated store data,
// and aligned/extended load data for writeback.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic        we,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    assign be         = we ? be_of(size, offset) : 4'b1111;
    assign lane_wdata = lane_data(size, wdata);
    assign load_data  = ext_load(size, zext, offset, rdata);

endmodule

// File: rtl/lsu_unit.sv
// Single-outstanding load/store unit driving an ack-based data memory.
// Build option: MISALIGN_TRAP_EN traps misaligned half/word accesses.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              we_q, zext_q, err_q, mis_q;
    logic [1:0]        sz_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [1:0]        sz_in;
    logic              bad_in, last_wait;
    logic [3:0]        be;
    logic [31:0]       lane_wdata, load_data;

    assign sz_in     = norm_size(req.req_size);
    assign last_wait = (cnt == CW'(MAX_WAIT - 1));

`ifdef MISALIGN_TRAP_EN
    assign bad_in = is_misaligned(sz_in, req.req_addr[1:0]);
`else
    assign bad_in = 1'b0;
`endif

    lsu_align u_align (
        .size       (sz_q),
        .zext       (zext_q),
        .we         (we_q),
        .offset     (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem.mem_rdata),
        .be         (be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            zext_q  <= 1'b0;
            sz_q    <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == ST_IDLE && req.req_valid) begin
                we_q    <= req.req_we;
                zext_q  <= req.req_unsigned;
                sz_q    <= sz_in;
                // Misaligned low bits are dropped when no trap is taken.
                addr_q  <= {req.req_addr[ADDR_W-1:2],
                            force_align(sz_in, req.req_addr[1:0])};
                wdata_q <= req.req_wdata;
                err_q   <= bad_in;
                mis_q   <= bad_in;
                rdata_q <= '0;
            end
            if (state == ST_ACCESS) begin
                if (mem.mem_ack) begin
                    err_q   <= 1'b0;
                    rdata_q <= we_q ? 32'h0 : load_data;
                end else if (last_wait) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        req.req_ready  = 1'b0;
        req.stall      = 1'b0;
        req.resp_valid = 1'b0;
        req.resp_err   = 1'b0;
        req.resp_rdata = '0;
        req.misalign   = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_be     = '0;
        mem.mem_wdata  = '0;
        unique case (state)
            ST_IDLE: begin
                req.req_ready = 1'b1;
                req.stall     = req.req_valid;
                if (req.req_valid) begin
                    state_nx = bad_in ? ST_RESP : ST_ACCESS;
                    cnt_nx   = '0;
                end
            end
            ST_ACCESS: begin
                req.stall     = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem.mem_be    = be;
                mem.mem_wdata = lane_wdata;
                // An ack on the final wait cycle still completes normally.
                if (mem.mem_ack || last_wait) begin
                    state_nx = ST_RESP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_RESP: begin
                req.resp_valid = 1'b1;
                req.resp_err   = err_q;
                req.resp_rdata = rdata_q;
                req.misalign   = mis_q;
                state_nx       = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: random loads/stores against a
// byte-level memory model, plus directed timeout and reset cases.
module tb_lsu_unit;

    localparam int MAXW = 8;

    typedef struct packed {
        logic        err;
        logic        mis;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if #(.ADDR_W(32)) rq ();
    lsu_mem_if #(.ADDR_W(32)) mi ();

    lsu_unit #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .req (rq),
        .mem (mi)
    );

    resp_t       resp_q[$];
    txn_t        txn_q[$];
    logic [31:0] ram[16];
    int          total = 0;
    int          bad   = 0;
    int          ack_delay = 0;
    logic        force_ack = 1'b0;
    logic        seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay cycles of mem_req.
    initial begin
        int cnt;
        cnt = 0;
        mi.mem_ack   = 1'b0;
        mi.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mi.mem_req) begin
                mi.mem_ack   = (cnt == ack_delay);
                mi.mem_rdata = (cnt == ack_delay) ? ram[mi.mem_addr[5:2]]
                                                  : $urandom;
                cnt++;
            end else begin
                cnt = 0;
                mi.mem_ack   = force_ack | ($urandom_range(0, 7) == 0);
                mi.mem_rdata = $urandom;
            end
        end
    end

    // Memory-side monitor: one transaction check per request, store commit.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (mi.mem_req && !seen) begin
                seen = 1'b1;
                if (txn_q.size() == 0) begin
                    check("mem_unexpected", 32'(mi.mem_req), 32'h0);
                end else begin
                    t = txn_q.pop_front();
                    check("mem_addr", mi.mem_addr, t.addr);
                    check("mem_we", 32'(mi.mem_we), 32'(t.we));
                    check("mem_be", 32'(mi.mem_be), 32'(t.be));
                    if (t.we) check("mem_wdata", mi.mem_wdata, t.wdata);
                end
            end
            if (!mi.mem_req) seen = 1'b0;
            if (mi.mem_req && mi.mem_ack && mi.mem_we)
                for (int b = 0; b < 4; b++)
                    if (mi.mem_be[b])
                        ram[mi.mem_addr[5:2]][8*b +: 8] = mi.mem_wdata[8*b +: 8];
        end
    end

    // Response monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rq.resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 32'(rq.resp_valid), 32'h0);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_err", 32'(rq.resp_err), 32'(r.err));
                    check("misalign", 32'(rq.misalign), 32'(r.mis));
                    check("resp_rdata", rq.resp_rdata, r.rdata);
                    check("mem_req_in_resp", 32'(mi.mem_req), 32'h0);
                end
            end
        end
    end

    task automatic do_op(input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] d, input int delay);
        logic [1:0]  sz, off;
        logic        mis, trap, tout, stall_ok;
        logic [31:0] word, v, wd;
        logic [3:0]  be;
        int          k, lat;
        @(posedge clk);
        #1;
        k = 0;
        while (!rq.req_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("ready_wait", 32'(rq.req_ready), 32'h1);
        sz  = (size == 2'd3) ? 2'd2 : size;
        off = addr[1:0];
        mis = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
        if (sz == 2'd1) off = off & 2'd2;
        if (sz == 2'd2) off = 2'd0;
`endif
        tout = !trap && (delay >= MAXW);
        word = ram[addr[5:2]];
        if (sz == 2'd0) begin
            be = 4'(1 << off);
            wd = {24'h0, d[7:0]} * 32'h01010101;
            v  = (word >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            be = (off >= 2) ? 4'b1100 : 4'b0011;
            wd = {16'h0, d[15:0]} * 32'h00010001;
            v  = (word >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            be = 4'b1111;
            wd = d;
            v  = word;
        end
        if (!we) be = 4'b1111;
        if (!trap) txn_q.push_back('{addr & 32'hFFFFFFFC, we, be, wd});
        resp_q.push_back('{trap || tout, trap,
                           (trap || tout || we) ? 32'h0 : v});
        lat = trap ? 2 : (tout ? 2 + MAXW : 3 + delay);
        ack_delay       = delay;
        rq.req_valid    = 1'b1;
        rq.req_we       = we;
        rq.req_size     = size;
        rq.req_unsigned = uns;
        rq.req_addr     = addr;
        rq.req_wdata    = d;
        k = 0;
        stall_ok = 1'b1;
        forever begin
            @(negedge clk);
            k++;
            if (rq.stall !== !rq.resp_valid) stall_ok = 1'b0;
            if (rq.resp_valid || k > 40) break;
            @(posedge clk);
            #1;
            // Requests while busy must be ignored.
            rq.req_valid = (k == 1) && !trap && ($urandom_range(0, 1) == 1);
            rq.req_addr  = $urandom;
            rq.req_we    = $urandom_range(0, 1) == 1;
        end
        rq.req_valid = 1'b0;
        check("latency", 32'(k), 32'(lat));
        check("stall", 32'(stall_ok), 32'h1);
    endtask

    initial begin
        rq.req_valid    = 1'b0;
        rq.req_we       = 1'b0;
        rq.req_size     = 2'd0;
        rq.req_unsigned = 1'b0;
        rq.req_addr     = '0;
        rq.req_wdata    = '0;
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(rq.req_ready), 32'h1);
        check("rst_outs", {rq.stall, rq.resp_valid, rq.resp_err, rq.misalign,
                           mi.mem_req, mi.mem_we, mi.mem_be}, 32'h0);
        check("rst_bus", mi.mem_addr | mi.mem_wdata | rq.resp_rdata, 32'h0);
        rst = 1'b1;

        do_op(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 2);
        ram[0] = 32'h80AA5511;
        do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0);
        do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1);
        do_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 100);
        do_op(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, MAXW - 1);

        // Abort an access with reset; a late ack must not resurrect it.
        @(posedge clk);
        #1;
        ack_delay       = 100;
        txn_q.push_back('{32'h10C, 1'b0, 4'b1111, 32'h0});
        rq.req_valid    = 1'b1;
        rq.req_we       = 1'b0;
        rq.req_size     = 2'd2;
        rq.req_addr     = 32'h10C;
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_req", 32'(mi.mem_req), 32'h0);
        check("abort_ready", 32'(rq.req_ready), 32'h1);
        check("abort_resp", 32'(rq.resp_valid), 32'h0);
        force_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_idle", {31'h0, rq.req_ready & !rq.resp_valid},
                  32'h1);
        end
        force_ack = 1'b0;
        txn_q.delete();

        do_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0);

        for (int n = 0; n < 150; n++) begin
            int r, dl;
            r  = $urandom_range(0, 15);
            dl = (r < 10) ? r % 4 : (r < 13) ? MAXW - 1 : (r < 15) ? MAXW : 30;
            do_op($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, 32'h100 + $urandom_range(0, 63),
                  $urandom, dl);
        end

        repeat (4) @(negedge clk);
        check("drain_resp", 32'(resp_q.size()), 32'h0);
        check("drain_mem", 32'(txn_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
